// File: rtl/crc_ccitt_checker_if.sv
// Byte stream into the CRC-16/CCITT frame checker and the per-frame result bus.
// in_valid qualifies in_data/in_last each cycle; there is no ready, so every valid byte is accepted.
interface crc_ccitt_checker_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        frame_done;
  logic        frame_ok;
  logic        len_err;
  logic [15:0] fcs_rx;
  logic [15:0] crc_calc;
  logic [10:0] byte_count;

  modport master (
    output in_valid, in_data, in_last,
    input  frame_done, frame_ok, len_err, fcs_rx, crc_calc, byte_count
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output frame_done, frame_ok, len_err, fcs_rx, crc_calc, byte_count
  );
endinterface

// File: rtl/crc_ccitt_checker.sv
// Receive-side CRC-16/CCITT (0x1021, init 0xFFFF) frame checker with length limits.
// The running CRC covers the FCS too, so a good frame leaves a zero residue.
module crc_ccitt_checker #(
  parameter int MAX_LEN = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  crc_ccitt_checker_if.slave   rx,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);

  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [10:0] sat11(input logic [11:0] v);
    return v[11] ? 11'h7FF : v[10:0];
  endfunction

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_prev_q, crc_prev_d;
  logic [10:0] count_q, count_d;
  logic [7:0]  prev_byte_q, prev_byte_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        len_err_q, len_err_d;
  logic [15:0] fcs_q, fcs_d;
  logic [15:0] calc_q, calc_d;
  logic [10:0] bcount_q, bcount_d;

  logic [15:0] crc_upd;
  logic [15:0] crc_first;
  logic [11:0] count_inc;
  logic        total_bad;

  assign crc_upd   = crc_byte(crc_q, rx.in_data);
  assign crc_first = crc_byte(CRC_INIT, rx.in_data);
  assign count_inc = {1'b0, count_q} + 12'd1;
  assign total_bad = (count_inc > MAX_LEN_W) || (count_inc < 12'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      crc_q       <= CRC_INIT;
      crc_prev_q  <= CRC_INIT;
      count_q     <= '0;
      prev_byte_q <= '0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      len_err_q   <= 1'b0;
      fcs_q       <= '0;
      calc_q      <= CRC_INIT;
      bcount_q    <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      crc_prev_q  <= crc_prev_d;
      count_q     <= count_d;
      prev_byte_q <= prev_byte_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      len_err_q   <= len_err_d;
      fcs_q       <= fcs_d;
      calc_q      <= calc_d;
      bcount_q    <= bcount_d;
    end
  end

  // crc_prev holds the CRC before the latest byte; at in_last it therefore excludes both FCS bytes.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    crc_prev_d  = crc_prev_q;
    count_d     = count_q;
    prev_byte_d = prev_byte_q;
    done_d      = 1'b0;
    ok_d        = ok_q;
    len_err_d   = len_err_q;
    fcs_d       = fcs_q;
    calc_d      = calc_q;
    bcount_d    = bcount_q;
    if (rx.in_valid) begin
      prev_byte_d = rx.in_data;
      case (state_q)
        IDLE: begin
          if (rx.in_last) begin
            done_d    = 1'b1;
            ok_d      = 1'b0;
            len_err_d = 1'b1;
            fcs_d     = {8'h00, rx.in_data};
            calc_d    = CRC_INIT;
            bcount_d  = 11'd1;
            crc_d     = CRC_INIT;
          end else begin
            state_d    = RECV;
            crc_d      = crc_first;
            crc_prev_d = CRC_INIT;
            count_d    = 11'd1;
          end
        end
        RECV: begin
          if (rx.in_last) begin
            done_d    = 1'b1;
            len_err_d = total_bad;
            ok_d      = (crc_upd == 16'h0000) && !total_bad;
            fcs_d     = {prev_byte_q, rx.in_data};
            calc_d    = crc_prev_q;
            bcount_d  = sat11(count_inc);
            state_d   = IDLE;
            crc_d     = CRC_INIT;
            count_d   = '0;
          end else begin
            count_d = sat11(count_inc);
            if (count_inc > MAX_LEN_W) begin
              state_d = DROP;
            end else begin
              crc_d      = crc_upd;
              crc_prev_d = crc_q;
            end
          end
        end
        DROP: begin
          count_d = sat11(count_inc);
          if (rx.in_last) begin
            done_d    = 1'b1;
            ok_d      = 1'b0;
            len_err_d = 1'b1;
            fcs_d     = {prev_byte_q, rx.in_data};
            calc_d    = crc_prev_q;
            bcount_d  = sat11(count_inc);
            state_d   = IDLE;
            crc_d     = CRC_INIT;
            count_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx.frame_done = done_q;
  assign rx.frame_ok   = ok_q;
  assign rx.len_err    = len_err_q;
  assign rx.fcs_rx     = fcs_q;
  assign rx.crc_calc   = calc_q;
  assign rx.byte_count = bcount_q;
  assign state_o       = state_q;

endmodule

// File: doc/crc_ccitt_checker.md
CRC_CCITT_CHECKER -- requirements
Module: crc_ccitt_checker

Interface
REQ-001 Parameter: MAX_LEN, 1024, maximum frame length in bytes, FCS included; legal range 3..2047.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  qualifies in_data/in_last for the current cycle; no backpressure.
REQ-005 in_data  input  8  received byte; frame order is payload, then FCS high byte, then FCS low byte.
REQ-006 in_last  input  1  marks the final byte of a frame (FCS low byte); ignored when in_valid=0.
REQ-007 frame_done  output  1  one-cycle pulse: frame result valid.
REQ-008 frame_ok  output  1  frame passed CRC and length checks; valid when frame_done=1.
REQ-009 len_err  output  1  frame too short (<3 bytes) or too long (>MAX_LEN); valid when frame_done=1.
REQ-010 fcs_rx  output  16  received FCS, {second-last byte, last byte}; valid when frame_done=1.
REQ-011 crc_calc  output  16  CRC over payload bytes only, excluding FCS; valid when frame_done=1.
REQ-012 byte_count  output  11  total bytes in the frame, saturating at 2047; valid when frame_done=1.

Function
REQ-013 CRC: CRC-16/CCITT, polynomial 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR.
REQ-014 Byte update: one update per accepted byte, equal to 8 serial shifts with data bit 7 first.
REQ-015 Running register: covers all bytes, FCS included; a correct frame leaves residue 0x0000.
REQ-016 Payload-only CRC: kept as a two-deep delayed copy of the running register, so crc_calc excludes the last two bytes.
REQ-017 States: IDLE, RECV, DROP.
REQ-018 IDLE transitions:
- in_valid=1, in_last=0: go to RECV; CRC loads init updated by the byte; count=1.
- in_valid=1, in_last=1: 1-byte frame; frame_done next cycle with len_err=1, frame_ok=0; stay IDLE.
REQ-019 RECV, in_valid=1, in_last=0: update CRC; increment count; if count would exceed MAX_LEN, go to DROP.
REQ-020 RECV, in_valid=1, in_last=1: finish the frame; frame_done next cycle; return to IDLE.
REQ-021 DROP: CRC frozen; count saturates; on in_valid & in_last, frame_done next cycle with len_err=1, frame_ok=0; return to IDLE.
REQ-022 in_valid=0 in any state: no change of CRC, count or state; gaps between bytes are unlimited.
REQ-023 Result latency: frame_done asserts exactly one cycle after the in_last byte and lasts one cycle.
REQ-024 Result hold: frame_ok, len_err, fcs_rx, crc_calc and byte_count are registered and hold until the next frame_done.
REQ-025 frame_ok = 1 only when final residue == 0x0000 and 3 <= byte_count <= MAX_LEN.
REQ-026 Back-to-back frames: a byte with in_valid=1 in the cycle after in_last starts a new frame with init 0xFFFF; frame_done for the previous frame asserts in that same cycle.
REQ-027 Two-byte frame: frame_done with len_err=1 and frame_ok=0; fcs_rx still reports the two bytes.

Reset
REQ-028 Reset forces IDLE and CRC=0xFFFF.
REQ-029 Reset values: frame_done=0, frame_ok=0, len_err=0, fcs_rx=0x0000, crc_calc=0xFFFF, byte_count=0.
REQ-030 Reset has priority over in_valid; a frame in progress is discarded with no frame_done, and the first valid byte after reset release starts a new frame.

Verification
REQ-031 Good frame: "123456789" (0x31..0x39) then 0x29, 0xB1 with last on 0xB1 -> one cycle later frame_done=1, frame_ok=1, crc_calc=0x29B1, fcs_rx=0x29B1, byte_count=11, len_err=0.
REQ-032 Corrupted frame: same frame with 0x35 replaced by 0x34 -> frame_ok=0, len_err=0, fcs_rx=0x29B1, crc_calc≠0x29B1.
REQ-033 Length errors:
- single byte 0x00 with last -> len_err=1, frame_ok=0, byte_count=1.
- MAX_LEN=16 and a 20-byte frame -> len_err=1, frame_ok=0, DROP entered after byte 16, byte_count=20.
REQ-034 Gaps and back-to-back: good frame with random in_valid gaps, immediately followed by a second good frame -> two frame_done pulses, both frame_ok=1, results identical to the gap-free case.
REQ-035 Reset mid-frame: reset asserted after 5 bytes of a frame, then the good frame sent -> no frame_done for the aborted frame, then frame_ok=1.
